// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running up-counter bus.
// Duty updates are handshaked, double-buffered and committed only on a count wrap.
module count_pwm_gen #(
    parameter int unsigned W        = 4,
    parameter int unsigned DUTY_RST = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] count,
    input  logic [W:0]   duty_in,
    input  logic         duty_valid,
    output logic         duty_ready,
    input  logic         err_clr,
    output logic         pwm,
    output logic         period_done,
    output logic         seq_err
);

    localparam logic [W-1:0] CntMax   = {W{1'b1}};
    localparam logic [W:0]   DutyMax  = {1'b1, {W{1'b0}}};
    localparam logic [W:0]   DutyInit = (W + 1)'(DUTY_RST);

    logic [W-1:0] prev_cnt_q, prev_cnt_d;
    logic         prev_valid_q, prev_valid_d;
    logic         pending_q, pending_d;
    logic [W:0]   pend_val_q, pend_val_d;
    logic [W:0]   active_duty_q, active_duty_d;
    logic         pwm_q, pwm_d;
    logic         period_done_q, period_done_d;
    logic         seq_err_q, seq_err_d;

    logic [W-1:0] cnt_step;
    logic         wrap;
    logic         step_err;
    logic         accept;
    logic         commit;
    logic [W:0]   duty_sat;
    logic [W:0]   eff_duty;

    always_comb begin
        cnt_step = prev_cnt_q + W'(1);
        wrap     = prev_valid_q && (prev_cnt_q == CntMax) && (count == '0);
        step_err = prev_valid_q && (count != cnt_step);
        // accept and commit are mutually exclusive: accept needs pending clear, commit needs it set
        accept   = duty_valid && !pending_q;
        commit   = wrap && pending_q;
        duty_sat = (duty_in > DutyMax) ? DutyMax : duty_in;
        eff_duty = commit ? pend_val_q : active_duty_q;
    end

    always_comb begin
        prev_cnt_d    = count;
        prev_valid_d  = 1'b1;
        period_done_d = wrap;
        pwm_d         = ({1'b0, count} < eff_duty);
        pending_d     = pending_q;
        pend_val_d    = pend_val_q;
        active_duty_d = active_duty_q;
        seq_err_d     = seq_err_q;

        if (step_err) begin
            seq_err_d = 1'b1;
        end else if (err_clr) begin
            seq_err_d = 1'b0;
        end

        if (commit) begin
            active_duty_d = pend_val_q;
            pending_d     = 1'b0;
        end
        if (accept) begin
            pend_val_d = duty_sat;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cnt_q    <= '0;
            prev_valid_q  <= 1'b0;
            pending_q     <= 1'b0;
            pend_val_q    <= '0;
            active_duty_q <= DutyInit;
            pwm_q         <= 1'b0;
            period_done_q <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            prev_cnt_q    <= prev_cnt_d;
            prev_valid_q  <= prev_valid_d;
            pending_q     <= pending_d;
            pend_val_q    <= pend_val_d;
            active_duty_q <= active_duty_d;
            pwm_q         <= pwm_d;
            period_done_q <= period_done_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign duty_ready  = ~pending_q;
    assign pwm         = pwm_q;
    assign period_done = period_done_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen: stimulus queues expected outputs per cycle,
// a separate monitor pops and compares them after each clock edge.
module tb_count_pwm_gen;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       err_clr;
    logic       pwm;
    logic       period_done;
    logic       seq_err;

    count_pwm_gen #(
        .W        (4),
        .DUTY_RST (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .err_clr     (err_clr),
        .pwm         (pwm),
        .period_done (period_done),
        .seq_err     (seq_err)
    );

    typedef struct {
        bit pwm;
        bit pd;
        bit err;
        bit rdy;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   rec_n = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input bit got, input bit want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s rec=%0d got=%0b want=%0b", name, idx, got, want);
        end
    endtask

    // Monitor: every edge produces a new output set; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pwm", e.idx, pwm, e.pwm);
                check("period_done", e.idx, period_done, e.pd);
                check("seq_err", e.idx, seq_err, e.err);
                check("duty_ready", e.idx, duty_ready, e.rdy);
            end
        end
    end

    // Drive one cycle; expectations describe the outputs right after this sample edge.
    task automatic tick(input int c, input int duty, input bit pd, input bit err, input bit rdy,
                        input bit dv, input int din, input bit ec, input bit rst);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        count      = c[3:0];
        duty_valid = dv;
        duty_in    = din[4:0];
        err_clr    = ec;
        e.pwm = rst ? 1'b0 : (c < duty);
        e.pd  = pd;
        e.err = err;
        e.rdy = rdy;
        e.idx = rec_n;
        rec_n++;
        exp_q.push_back(e);
    endtask

    task automatic span(input int lo, input int hi, input int duty, input bit pd0, input bit err,
                        input bit rdy);
        for (int c = lo; c <= hi; c++) begin
            tick(c, duty, (c == lo) && pd0, err, rdy, 1'b0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        count      = '0;
        duty_valid = 1'b0;
        duty_in    = '0;
        err_clr    = 1'b0;

        // Reset and free-run with duty 0; no wrap on the first sample after reset
        tick(0, 0, 0, 0, 1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1, 0, 0, 0, 1);
        span(0, 15, 0, 0, 0, 1);
        span(0, 15, 0, 1, 0, 1);

        // Duty 5 written at count 7, takes effect at the wrap
        span(0, 6, 0, 1, 0, 1);
        tick(7, 0, 0, 0, 0, 1, 5, 0, 0);
        span(8, 15, 0, 0, 0, 0);
        span(0, 15, 5, 1, 0, 1);
        span(0, 15, 5, 1, 0, 1);

        // Duty 16 (always high), then 0 (always low), then 20 saturating to 16
        span(0, 2, 5, 1, 0, 1);
        tick(3, 5, 0, 0, 0, 1, 16, 0, 0);
        span(4, 15, 5, 0, 0, 0);
        span(0, 1, 16, 1, 0, 1);
        tick(2, 16, 0, 0, 0, 1, 0, 0, 0);
        span(3, 15, 16, 0, 0, 0);
        span(0, 8, 0, 1, 0, 1);
        tick(9, 0, 0, 0, 0, 1, 20, 0, 0);
        span(10, 15, 0, 0, 0, 0);
        span(0, 15, 16, 1, 0, 1);

        // Held valid while pending is ignored, then accepted once pending clears
        span(0, 0, 16, 1, 0, 1);
        tick(1, 16, 0, 0, 0, 1, 3, 0, 0);
        for (int c = 2; c <= 15; c++) tick(c, 16, 0, 0, 0, 1, 9, 0, 0);
        tick(0, 3, 1, 0, 1, 1, 9, 0, 0);
        tick(1, 3, 0, 0, 0, 1, 9, 0, 0);
        span(2, 15, 3, 0, 0, 0);
        span(0, 15, 9, 1, 0, 1);
        // Accept coincident with a wrap commits one period later
        tick(0, 9, 1, 0, 0, 1, 2, 0, 0);
        span(1, 15, 9, 0, 0, 0);
        span(0, 15, 2, 1, 0, 1);

        // Upstream counter reset at 10: error, no wrap, pending 7 not committed
        span(0, 3, 2, 1, 0, 1);
        tick(4, 2, 0, 0, 0, 1, 7, 0, 0);
        span(5, 10, 2, 0, 0, 0);
        tick(0, 2, 0, 1, 0, 0, 0, 0, 0);
        span(1, 2, 2, 0, 1, 0);
        tick(3, 2, 0, 0, 0, 0, 0, 1, 0);
        span(4, 15, 2, 0, 0, 0);
        span(0, 4, 7, 1, 0, 1);
        // Step error and err_clr together: set wins
        tick(9, 7, 0, 1, 1, 0, 0, 1, 0);
        span(10, 15, 7, 0, 1, 1);
        tick(0, 7, 1, 0, 1, 0, 0, 1, 0);

        // Mid-period reset with 12 active, 3 pending and seq_err set
        span(1, 2, 7, 0, 0, 1);
        tick(3, 7, 0, 0, 0, 1, 12, 0, 0);
        span(4, 15, 7, 0, 0, 0);
        span(0, 1, 12, 1, 0, 1);
        tick(2, 12, 0, 0, 0, 1, 3, 0, 0);
        span(3, 4, 12, 0, 0, 0);
        tick(8, 12, 0, 1, 0, 0, 0, 0, 0);
        tick(9, 0, 0, 0, 1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1, 0, 0, 0, 1);
        span(0, 15, 0, 0, 0, 1);
        span(0, 15, 0, 1, 0, 1);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_pwm_gen.md
Name: count_pwm_gen

Overview:
- Downstream consumer of the 4-bit T-flip-flop up-counter's count bus. Turns the free-running count into a registered PWM waveform.
- Duty updates are accepted through a valid/ready handshake and double-buffered, so they take effect only at a period boundary (count wraps MAX -> 0).
- Also emits a period-boundary pulse and a sticky error flag if the incoming count ever deviates from a +1 step.

Parameters:
- W, 4, width of the incoming count bus; period = 2^W cycles.
- DUTY_RST, 0, active duty value loaded at reset (range 0..2^W).

Ports:
- clk  input  1  clock, shared with the upstream counter.
- reset  input  1  synchronous, active-high reset.
- count  input  W  count value from the upstream counter, sampled every clk.
- duty_in  input  W+1  requested high-time in counts, 0..2^W; values above 2^W saturate to 2^W.
- duty_valid  input  1  duty_in is valid this cycle.
- duty_ready  output  1  pending buffer is empty and can accept a duty value.
- err_clr  input  1  clears seq_err.
- pwm  output  1  registered PWM output.
- period_done  output  1  one-cycle pulse when a wrap is detected.
- seq_err  output  1  sticky flag: count stepped by something other than +1 (mod 2^W).

Behaviour:
- Reset (synchronous, dominates all other inputs): pwm=0, period_done=0, seq_err=0, duty_ready=1, pending=0, active_duty=DUTY_RST, prev_valid=0, prev_cnt=0.
- Every cycle, the block registers prev_cnt<=count and sets prev_valid<=1.
- Wrap detection: wrap = prev_valid && prev_cnt==2^W-1 && count==0. No wrap is ever detected in the first cycle after reset.
- period_done is registered and equals wrap from the previous cycle: a 1-cycle pulse, one clk after count==0 is sampled.
- Sequence check:
  - step_err = prev_valid && count != (prev_cnt+1) mod 2^W.
  - seq_err <= 1 on step_err.
  - Else seq_err <= 0 on err_clr.
  - If step_err and err_clr occur in the same cycle, set wins.
  - prev_cnt always realigns to the current count, so a single glitch flags once, not repeatedly.
- Duty handshake:
  - duty_ready = ~pending (combinational from register).
  - Accept when duty_valid && duty_ready: pend_val <= min(duty_in, 2^W), pending <= 1.
  - duty_valid while not ready is ignored; the source must hold the value.
- Duty commit:
  - On a wrap cycle with pending=1: active_duty <= pend_val, pending <= 0.
  - If a value is accepted in the same cycle as a wrap, the accept occurs only if pending was already 0. In that case the new value stays pending and commits at the next wrap, not this one.
- PWM:
  - eff_duty = (wrap && pending) ? pend_val : active_duty.
  - pwm <= (count < eff_duty). Latency is 1 clk from count sample to pwm.
  - The committed duty therefore governs the count==0 sample of the new period.
  - duty=0 gives pwm always 0; duty=2^W gives pwm always 1.
  - The comparison is unsigned, done in W+1 bits.
- Upstream counter reset mid-period (count jumps to 0 from a value other than MAX): this is flagged as seq_err, is not a wrap, period_done stays low, and pending is not committed.
- Reset mid-operation discards any pending duty and restores DUTY_RST.

Test Plan:
1. Reset with DUTY_RST=0, counter free-running from 0: pwm stays 0; period_done pulses once every 16 clks, first pulse 1 clk after the count==0 that follows count==15; seq_err=0; duty_ready=1.
2. Write duty=5 at count=7 (valid&ready): duty_ready drops next cycle; pwm stays 0 until wrap; then pwm is high for exactly 5 clks per period (counts 0..4 sampled); duty_ready returns 1 the cycle after the wrap.
3. Write duty=16, then duty=0 in later periods: pwm is constantly 1 for a full period, then constantly 0. Write duty=20: saturates and behaves as 16.
4. Hold duty_valid with 9 while pending=1: no second accept; once pending clears, 9 is accepted. Accept coincident with a wrap cycle: value commits one period later.
5. Pulse the upstream counter reset at count=10: count goes 10 -> 0; seq_err=1 the next cycle, no period_done pulse, pending duty not committed; err_clr clears it; wrap and period_done resume on the next 15 -> 0.
6. Assert reset mid-period with duty=12 active and duty=3 pending: all outputs return to reset values; pending is lost; the first period after reset uses DUTY_RST.
